// File: rtl/seven_seg_display.sv
// Multi-digit seven-segment driver: binary to hex/decimal digits,
// with blanking, decimal points, overflow dashes and blinking.
module seven_seg_display #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20,
    parameter int BLINK_HALF = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blink_en,
    output logic                    busy,
    output logic [8*NUM_DIGITS-1:0] segments
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int SW    = DW + VALUE_W;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int BW    = $clog2(BLINK_HALF);

    localparam logic [63:0]      DEC_MAX   = 64'(10 ** NUM_DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);
    localparam logic [BW-1:0]    BLINK_TOP = BW'(BLINK_HALF - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]         digits_q, digits_d;
    logic                  ovf_q, ovf_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic [CNT_W-1:0]      step_q, step_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;

    logic          accept;
    logic          last_step;
    logic [63:0]   value_ext;
    logic [SW-1:0] dd_adj;
    logic [SW-1:0] dd_step;

    assign value_ext = 64'(value);
    assign accept    = load && (state_q == S_IDLE);
    assign last_step = (step_q == LAST_STEP);
    assign segments  = seg_q;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        g = 8'hFF;
        case (d)
            4'h0: g = 8'hC0;
            4'h1: g = 8'hF9;
            4'h2: g = 8'hA4;
            4'h3: g = 8'hB0;
            4'h4: g = 8'h99;
            4'h5: g = 8'h92;
            4'h6: g = 8'h82;
            4'h7: g = 8'hF8;
            4'h8: g = 8'h80;
            4'h9: g = 8'h90;
            4'hA: g = 8'h88;
            4'hB: g = 8'h83;
            4'hC: g = 8'hC6;
            4'hD: g = 8'hA1;
            4'hE: g = 8'h86;
            4'hF: g = 8'h8E;
        endcase
        return g;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && !hex_mode) state_d = S_CONV;
            S_CONV: if (last_step) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_CONV);
    end

    // One double-dabble step over {bcd, binary}
    always_comb begin
        dd_adj = sh_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sh_q[VALUE_W+4*i +: 4] >= 4'd5) begin
                dd_adj[VALUE_W+4*i +: 4] = sh_q[VALUE_W+4*i +: 4] + 4'd3;
            end
        end
        dd_step = dd_adj << 1;
    end

    always_comb begin
        sh_d       = sh_q;
        step_d     = step_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;
        if (accept) begin
            if (hex_mode) begin
                digits_d = value_ext[DW-1:0];
                ovf_d    = (value_ext >> DW) != 64'd0;
            end else begin
                sh_d       = {{DW{1'b0}}, value};
                step_d     = '0;
                ovf_pend_d = value_ext > DEC_MAX;
            end
        end else if (state_q == S_CONV) begin
            sh_d   = dd_step;
            step_d = step_q + CNT_W'(1);
            // Display keeps old digits until the full result is ready
            if (last_step) begin
                digits_d = dd_step[SW-1:VALUE_W];
                ovf_d    = ovf_pend_q;
            end
        end
    end

    always_comb begin
        bcnt_d  = bcnt_q + BW'(1);
        phase_d = phase_q;
        if (bcnt_q == BLINK_TOP) begin
            bcnt_d  = '0;
            phase_d = !phase_q;
        end
    end

    // Digits are scanned from the top so blanking knows what lies above
    always_comb begin
        logic       nz_seen;
        logic       blank;
        logic [3:0] nib;
        logic [7:0] seg_b;
        seg_d   = '1;
        nz_seen = 1'b0;
        blank   = 1'b0;
        nib     = 4'h0;
        seg_b   = 8'hFF;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib     = digits_q[4*i +: 4];
            nz_seen = nz_seen || (nib != 4'h0);
            blank   = blank_lz && !nz_seen && (i != 0);
            seg_b   = blank ? 8'hFF : glyph(nib);
            if (dp_mask[i]) seg_b[7] = 1'b0;
            if (ovf_q) seg_b = 8'hBF;
            if (blink_en && !phase_q) seg_b = 8'hFF;
            seg_d[8*i +: 8] = seg_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            sh_q       <= '0;
            step_q     <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b1;
            seg_q      <= '1;
        end else begin
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            sh_q       <= sh_d;
            step_q     <= step_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            seg_q      <= seg_d;
        end
    end

endmodule

// File: doc/seven_seg_display.md
Name: seven_seg_display

Overview:
- Parametrised multi-digit seven-segment driver.
- Converts a binary value to NUM_DIGITS display digits, in either decimal or hex. Decimal conversion is a sequential shift-add-3 (double-dabble) with a load/busy handshake; hex is loaded in one cycle.
- Adds leading-zero blanking, per-digit decimal points, overflow indication and blinking.
- Sits between datapath counters/registers and the board's HEX display pins.

Parameters:
- NUM_DIGITS, 6, number of displays driven (1..8).
- VALUE_W, 20, width of binary input (4..32); must satisfy 2**VALUE_W > 10**NUM_DIGITS - 1 or decimal overflow never occurs.
- BLINK_HALF, 25000000, clock cycles per blink half-period (>=2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- value  input  VALUE_W  binary number to display
- load  input  1  request to latch value; accepted when busy=0
- hex_mode  input  1  1=hex, 0=decimal; sampled on accepted load
- blank_lz  input  1  blank leading zeros (live)
- dp_mask  input  NUM_DIGITS  bit i lights the DP of digit i (live)
- blink_en  input  1  enable blinking of whole display (live)
- busy  output  1  decimal conversion in progress
- segments  output  8*NUM_DIGITS  digit i at [8i+7:8i]

Behaviour:
- Segment encoding per digit: active-low. Bit7=DP, bits6..0 = g,f,e,d,c,b,a. Digit 0 is least significant.
- Hex glyphs:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Special glyphs: dash=BF, blank=FF.
- Reset (async):
  - segments = all 1s; busy = 0.
  - Digit register = 0; ovf = 0.
  - Blink counter = 0; blink phase = on.
  - Any conversion in progress is abandoned.
- Load acceptance:
  - Edge E0 with load=1 and busy=0 accepts the load. value and hex_mode are captured at E0.
  - load while busy=1 is ignored; no queueing.
- Hex mode:
  - Digit register takes value[4*NUM_DIGITS-1:0] nibbles at E0. busy never asserts.
  - ovf=1 if any value bit above 4*NUM_DIGITS-1 is set.
- Decimal mode:
  - At E0: busy goes 1; shift register loaded; ovf computed as (value > 10**NUM_DIGITS - 1).
  - Edges E1..E_VALUE_W: one double-dabble step each (add 3 to any BCD nibble >=5, then shift left 1).
  - At E_VALUE_W: digit register and ovf updated, busy goes 0. A new load is accepted at E_VALUE_W+1 at the earliest.
  - Displayed digits hold their old values throughout conversion (no flicker).
- segments is a registered output, recomputed every edge from the digit register, ovf, blank_lz, dp_mask and blink phase. The display therefore changes one edge after the digit register: E1 for hex, E_VALUE_W+1 for decimal.
- Leading-zero blanking: when blank_lz=1, every digit above the most significant nonzero digit shows blank (FF). Digit 0 is never blanked, so value 0 shows "0".
- Decimal point: bit7 is forced 0 when dp_mask[i]=1, including on blanked digits.
- Overflow: when ovf=1, all digits show dash (BF) with DPs off, regardless of blank_lz and dp_mask.
- Blink:
  - Counter free-runs 0..BLINK_HALF-1 and wraps; the phase toggles on each wrap.
  - When blink_en=1 and phase=off, all segments are 1s including DP.
  - blink_en=0 always shows the display; the counter keeps running.
- Simultaneous events: a load at the same edge a conversion finishes is not accepted, because busy is still 1 at that edge.

Test Plan:
- Assert rst mid-sim, asynchronously between edges -> segments immediately all FF, busy=0. After release with no load, display shows "000000", i.e. every byte C0.
- Decimal load value=1234, blank_lz=0 (defaults) -> busy high exactly 20 cycles. One edge later, segments (digit5..0) = C0,C0,F9,A4,B0,99. With blank_lz=1 -> FF,FF,F9,A4,B0,99.
- Decimal value=1000000 -> all digits BF. Then value=999999 -> all digits 90. value=0 with blank_lz=1 -> FF x5, C0.
- hex_mode=1, value=20'hBEEF, dp_mask=6'b000100 -> busy stays 0. Next edge: C0,C0,83,86,86,8E with digit2 = 06. hex value=20'h1_0000 with NUM_DIGITS=4 -> dashes.
- Decimal load 42, pulse load with value 77 at cycle 5 of busy -> second load ignored, final display 42, busy low after 20 cycles.
- blink_en=1, BLINK_HALF=4 -> display alternates 4 cycles shown / 4 cycles all-FF. Assert rst during a conversion -> busy=0, old display cleared to FF, no later spurious update.
